// File: rtl/neo_watchdog.sv
// Frame watchdog: counts VBLANK rising edges and, unless kicked, drives an
// active-low reset pulse of RST_CYCLES enabled cycles into the cell array.
module neo_watchdog #(
  parameter int WD_FRAMES  = 8,
  parameter int RST_CYCLES = 256
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CLK_EN,
  input  logic       VBLANK,
  input  logic       WDOG_KICK,
  input  logic       WDOG_DISABLE,
  output logic       nWDOG_RESET,
  output logic       WDOG_TRIP,
  output logic [3:0] WDOG_COUNT
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_FIRE = 1'b1
  } state_t;

  localparam logic [3:0]  COUNT_LAST = 4'(WD_FRAMES - 1);
  localparam logic [3:0]  COUNT_FULL = 4'(WD_FRAMES);
  localparam logic [15:0] PULSE_LOAD = 16'(RST_CYCLES - 1);

  state_t      state_q;
  logic        vb_q;
  logic [3:0]  count_q;
  logic [15:0] pulse_q;
  logic        nrst_q;
  logic        trip_q;
  logic        vb_rise;

  // vb_q resets high so a VBLANK already asserted at reset release is not an edge.
  assign vb_rise = VBLANK & ~vb_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_RUN;
      vb_q    <= 1'b1;
      count_q <= 4'd0;
      pulse_q <= 16'd0;
      nrst_q  <= 1'b1;
      trip_q  <= 1'b0;
    end else if (CLK_EN) begin
      vb_q   <= VBLANK;
      trip_q <= 1'b0;
      case (state_q)
        ST_RUN: begin
          if (WDOG_DISABLE || WDOG_KICK) begin
            count_q <= 4'd0;
          end else if (vb_rise) begin
            if (count_q == COUNT_LAST) begin
              state_q <= ST_FIRE;
              count_q <= COUNT_FULL;
              trip_q  <= 1'b1;
              nrst_q  <= 1'b0;
              pulse_q <= PULSE_LOAD;
            end else begin
              count_q <= count_q + 4'd1;
            end
          end
        end
        ST_FIRE: begin
          // The pulse always runs to completion; only RESET can cut it short.
          if (pulse_q == 16'd0) begin
            state_q <= ST_RUN;
            count_q <= 4'd0;
            nrst_q  <= 1'b1;
          end else begin
            pulse_q <= pulse_q - 16'd1;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign nWDOG_RESET = nrst_q;
  assign WDOG_TRIP   = trip_q;
  assign WDOG_COUNT  = count_q;

endmodule

// File: doc/neo_watchdog.md
# neo_watchdog

Frame-based watchdog for the NeoGeo core: counts VBLANK rising edges from the LSPC and, unless the 68k kicks it (decoded write to $300001), fires an active-low system reset pulse. It sits directly upstream of the flip-flop cell array: `nWDOG_RESET` is ANDed into the nR/R pins of the FDP/FD cells and the 68k reset tree. All logic is synchronous to the master clock and qualified by the core's clock enable.

## Interface
- `WD_FRAMES`, default 8: number of VBLANK rising edges without a kick before expiry; legal range 1..15.
- `RST_CYCLES`, default 256: length of the reset pulse in enabled cycles; legal range 1..65535.
- `CLK`  in  1  master clock; all state changes on its rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `CLK_EN`  in  1  clock enable; state advances only when high, except that `RESET` acts regardless of `CLK_EN`.
- `VBLANK`  in  1  level VBLANK from the LSPC, synchronous to `CLK`.
- `WDOG_KICK`  in  1  single-cycle strobe; write to $300001.
- `WDOG_DISABLE`  in  1  debug/DIP watchdog disable.
- `nWDOG_RESET`  out  1  active-low reset to the downstream cells and the 68k.
- `WDOG_TRIP`  out  1  one-cycle pulse marking expiry.
- `WDOG_COUNT`  out  4  current frame count, for debug and the bench.

## Operation
- Reset values: `nWDOG_RESET`=1, `WDOG_TRIP`=0, `WDOG_COUNT`=0, state=RUN, VBLANK history register `vb_q`=1.
  - `vb_q` resets to 1 so that a VBLANK already high at reset release is not counted.
- Edge detect: `edge` = `VBLANK` & ~`vb_q`. `vb_q` <= `VBLANK` on every enabled cycle, in every state.
- State RUN:
  - Kick: `WDOG_KICK` clears the count to 0. When a kick and an edge occur in the same cycle, the kick wins and the count becomes 0.
  - Edge without kick, count < `WD_FRAMES`-1: count increments by 1.
  - Edge without kick, count == `WD_FRAMES`-1: go to FIRE. Count becomes `WD_FRAMES`. `WDOG_TRIP`=1 for that one enabled cycle.
  - `WDOG_DISABLE`=1: count forced to 0 and held; no transition to FIRE; kicks have no effect.
- State FIRE:
  - `nWDOG_RESET`=0 for exactly `RST_CYCLES` enabled cycles. A 16-bit down-counter is loaded with `RST_CYCLES`-1 on entry.
  - Kicks, edges and `WDOG_DISABLE` are ignored; a pulse that has started always completes.
  - When the pulse counter reaches 0: return to RUN with count 0 and `nWDOG_RESET`=1.
- `RESET` high at any time, including mid-FIRE: all registers take their reset values on that edge, so `nWDOG_RESET` returns to 1 immediately.
- Outputs are registered; no combinational path from inputs to outputs.
- Count saturates at `WD_FRAMES`. The count never wraps.

## Timing
- Kick-to-count latency: 1 enabled cycle. `WDOG_COUNT`=0 is visible after the rising edge of `CLK` at which the kick is sampled.
- Edge-to-count latency: 1 enabled cycle after `VBLANK` is first sampled high (same edge as `vb_q` update).
- Expiry: `WDOG_TRIP` and `nWDOG_RESET`=0 both assert on the same clock edge, the one that samples the final VBLANK edge.
- `nWDOG_RESET` stays low for `RST_CYCLES` enabled cycles, then goes high on the following enabled edge.
- With `CLK_EN`=0, every register holds its value; `WDOG_TRIP` stays 1 until the next enabled cycle.
- Worst-case time to fire from the last kick: `WD_FRAMES` frames, i.e. 8 × 16.7 ms ≈ 133 ms at the default.

## Test plan
- Reset release with `VBLANK` held high, `WD_FRAMES`=3, `RST_CYCLES`=4 -> `WDOG_COUNT`=0, `nWDOG_RESET`=1. The first counted edge is the next low-to-high transition of `VBLANK`.
- Three VBLANK edges with no kick, `CLK_EN`=1 -> count goes 1, 2, then `WDOG_TRIP` pulses once and `nWDOG_RESET`=0 for exactly 4 cycles. The block then returns to RUN with count 0.
- Kick on the same cycle as the second edge -> count 0, not 2. Three further edges are then needed to fire.
- Kick strobed every 2 frames over 20 frames -> `nWDOG_RESET` never drops; count never exceeds 2.
- `RESET` asserted on the 2nd cycle of FIRE -> `nWDOG_RESET`=1 on the next edge; count 0; no residual pulse afterwards.
- `CLK_EN` toggled at 1/4 rate with `WDOG_DISABLE`=1 for 10 edges, then 0 -> no fire while disabled. After the disable is removed, the pulse length is measured as 4 enabled (not raw) cycles.
